// File: rtl/pooling_pkg.sv
// pooling_pkg: shared types and elaboration helpers for the pooling_layers blocks.
//   pool_state_e : sequence phase (leading pad, body, trailing pad)
//   out_len      : pooled outputs per sequence for length l, kernel k, stride s, pad p
//   pad_value    : most-negative value of a width-bit element (returned in 64 bits)
package pooling_pkg;

    typedef enum logic [1:0] {
        ST_LEAD = 2'd0,
        ST_BODY = 2'd1,
        ST_TAIL = 2'd2
    } pool_state_e;

    localparam int unsigned PAD_VALUE_W = 64;

    function automatic int unsigned out_len(input int unsigned l, input int unsigned k,
                                            input int unsigned s, input int unsigned p);
        return (l + 2 * p - k) / s + 1;
    endfunction

    // Signed: sign bit only; unsigned: zero.
    function automatic logic [PAD_VALUE_W-1:0] pad_value(input int unsigned width,
                                                         input bit          is_signed);
        return is_signed ? (PAD_VALUE_W'(1) << (width - 1)) : '0;
    endfunction

endpackage

// File: rtl/max_tree.sv
// max_tree: combinational maximum of K elements of one lane.
//   din    : K elements, W bits each
//   dout_c : largest element (two's-complement order when SIGNED, else unsigned)
module max_tree #(
    parameter int unsigned W      = 8,
    parameter int unsigned K      = 2,
    parameter bit          SIGNED = 1'b1
) (
    input  logic [K-1:0][W-1:0] din,
    output logic [W-1:0]        dout_c
);

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [W-1:0] FLIP = SIGNED ? (W'(1) << (W - 1)) : '0;

    always_comb begin
        dout_c = din[0];
        for (int i = 1; i < int'(K); i++) begin
            if ((din[i] ^ FLIP) > (dout_c ^ FLIP)) begin
                dout_c = din[i];
            end
        end
    end

endmodule

// File: rtl/maxpool1d_stream.sv
// maxpool1d_stream: streaming 1-D max-pool, all channels of one position per beat.
//   clk, rst          : clock, synchronous active-high reset
//   data_in_0*        : input position stream (valid/ready), lane c = channel c
//   data_out_0*       : pooled position stream (valid/ready), registered
// Each sequence walks padded coordinates 0 .. L+2P-1; pad positions are injected
// without consuming input. One padded position advances per cycle when the
// output register can accept a result.
module maxpool1d_stream
    import pooling_pkg::*;
#(
    parameter int unsigned DATA_IN_0_PRECISION_0       = 8,
    parameter int unsigned DATA_IN_0_PRECISION_1       = 3,
    parameter int unsigned DATA_IN_0_TENSOR_SIZE_DIM_0 = 4,
    parameter int unsigned DATA_IN_0_TENSOR_SIZE_DIM_1 = 8,
    parameter int unsigned KERNEL_SIZE                 = 2,
    parameter int unsigned STRIDE                      = 2,
    parameter int unsigned PADDING                     = 0,
    parameter int unsigned SIGNED                      = 1
) (
    input  logic                                                            clk,
    input  logic                                                            rst,
    input  logic [DATA_IN_0_TENSOR_SIZE_DIM_0-1:0][DATA_IN_0_PRECISION_0-1:0] data_in_0,
    input  logic                                                            data_in_0_valid,
    output logic                                                            data_in_0_ready,
    output logic [DATA_IN_0_TENSOR_SIZE_DIM_0-1:0][DATA_IN_0_PRECISION_0-1:0] data_out_0,
    output logic                                                            data_out_0_valid,
    input  logic                                                            data_out_0_ready
);

    localparam int unsigned W       = DATA_IN_0_PRECISION_0;
    localparam int unsigned C       = DATA_IN_0_TENSOR_SIZE_DIM_0;
    localparam int unsigned L       = DATA_IN_0_TENSOR_SIZE_DIM_1;
    localparam int unsigned K       = KERNEL_SIZE;
    localparam int unsigned S       = STRIDE;
    localparam int unsigned P       = PADDING;
    localparam int unsigned PADDED  = L + 2 * P;
    localparam int unsigned OUT_LEN = out_len(L, K, S, P);
    localparam int unsigned POS_W   = $clog2(PADDED + 1);
    localparam int unsigned STR_W   = $clog2(S + 1);
    localparam int unsigned OUT_W   = $clog2(OUT_LEN + 1);

    localparam logic [W-1:0]     PAD       = W'(pad_value(W, SIGNED != 0));
    localparam logic [POS_W-1:0] WIN_FULL  = POS_W'(K - 1);
    localparam logic [POS_W-1:0] LEAD_LAST = POS_W'((P > 0) ? P - 1 : 0);
    localparam logic [POS_W-1:0] BODY_LAST = POS_W'(P + L - 1);
    localparam logic [POS_W-1:0] SEQ_LAST  = POS_W'(PADDED - 1);

    // Fractional bits only travel with the data; they must fit the element.
    if (K < 1 || S < 1 || P >= K || K > PADDED || DATA_IN_0_PRECISION_1 > W) begin : g_bad_cfg
        $error("maxpool1d_stream: illegal pooling configuration");
    end

    pool_state_e                state;
    pool_state_e                state_next;
    logic [POS_W-1:0]           pos;
    logic [STR_W-1:0]           stride_cnt;
    logic [OUT_W-1:0]           out_cnt;
    logic [C-1:0][K-1:0][W-1:0] win;
    logic [C-1:0][K-1:0][W-1:0] win_cand;
    logic [C-1:0][W-1:0]        win_max;
    logic                       adv_ok;
    logic                       advance;
    logic                       seq_end;
    logic                       emit;

    // Phase sequencing, handshake and the candidate window (old window plus new position).
    always_comb begin
        state_next      = state;
        adv_ok          = !data_out_0_valid || data_out_0_ready;
        data_in_0_ready = 1'b0;
        advance         = 1'b0;
        unique case (state)
            ST_LEAD: begin
                advance = adv_ok;
                if (advance && pos == LEAD_LAST) state_next = ST_BODY;
            end
            ST_BODY: begin
                data_in_0_ready = adv_ok && !rst;
                advance         = adv_ok && data_in_0_valid;
                if (advance && pos == BODY_LAST) begin
                    if (P == 0) state_next = ST_BODY;
                    else        state_next = ST_TAIL;
                end
            end
            ST_TAIL: begin
                advance = adv_ok;
                if (advance && pos == SEQ_LAST) state_next = ST_LEAD;
            end
            default: begin
                if (P == 0) state_next = ST_BODY;
                else        state_next = ST_LEAD;
            end
        endcase
        seq_end = advance && pos == SEQ_LAST;
        emit    = advance && pos >= WIN_FULL && stride_cnt == '0 && out_cnt < OUT_W'(OUT_LEN);
        for (int c = 0; c < int'(C); c++) begin
            win_cand[c][0] = (state == ST_BODY) ? data_in_0[c] : PAD;
            for (int j = 1; j < int'(K); j++) begin
                win_cand[c][j] = win[c][j-1];
            end
        end
    end

    for (genvar g = 0; g < int'(C); g++) begin : g_lane
        max_tree #(
            .W      (W),
            .K      (K),
            .SIGNED (SIGNED != 0)
        ) u_max (
            .din    (win_cand[g]),
            .dout_c (win_max[g])
        );
    end

    // Phase register.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (P == 0) state <= ST_BODY;
            else        state <= ST_LEAD;
        end else begin
            state <= state_next;
        end
    end

    // Position/stride/output counters and the window; all restart at sequence end.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos        <= '0;
            stride_cnt <= '0;
            out_cnt    <= '0;
            win        <= {(C * K){PAD}};
        end else if (advance) begin
            if (seq_end) begin
                pos        <= '0;
                stride_cnt <= '0;
                out_cnt    <= '0;
                win        <= {(C * K){PAD}};
            end else begin
                pos <= pos + 1'b1;
                win <= win_cand;
                if (emit) begin
                    stride_cnt <= STR_W'(S - 1);
                    out_cnt    <= out_cnt + 1'b1;
                end else if (pos >= WIN_FULL && stride_cnt != '0) begin
                    stride_cnt <= stride_cnt - 1'b1;
                end
            end
        end
    end

    // Output register: a new result may replace one being drained in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_0       <= '0;
            data_out_0_valid <= 1'b0;
        end else if (emit) begin
            data_out_0       <= win_max;
            data_out_0_valid <= 1'b1;
        end else if (data_out_0_ready) begin
            data_out_0_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_maxpool1d_stream.sv
// Directed bench for maxpool1d_stream across several pooling configurations.
module tb_maxpool1d_stream;

    logic            clk = 1'b0;
    logic            rst;
    logic [0:0][7:0] din_1;
    logic [1:0][7:0] din_2;
    logic            vin;
    logic            ordy;

    logic a_rdy, a_vout, b_rdy, b_vout, c_rdy, c_vout, s_rdy, s_vout, u_rdy, u_vout;
    logic [0:0][7:0] a_dout, b_dout, c_dout;
    logic [1:0][7:0] s_dout, u_dout;

    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    logic [7:0]  qc[$];
    logic [15:0] qs[$];
    logic [15:0] qu[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // a: L=8 K=2 S=2 P=0
    maxpool1d_stream #(.DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(3),
        .DATA_IN_0_TENSOR_SIZE_DIM_0(1), .DATA_IN_0_TENSOR_SIZE_DIM_1(8),
        .KERNEL_SIZE(2), .STRIDE(2), .PADDING(0), .SIGNED(1)) u_a (
        .clk(clk), .rst(rst), .data_in_0(din_1), .data_in_0_valid(vin),
        .data_in_0_ready(a_rdy), .data_out_0(a_dout), .data_out_0_valid(a_vout),
        .data_out_0_ready(ordy));

    // b: L=5 K=3 S=1 P=1
    maxpool1d_stream #(.DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(3),
        .DATA_IN_0_TENSOR_SIZE_DIM_0(1), .DATA_IN_0_TENSOR_SIZE_DIM_1(5),
        .KERNEL_SIZE(3), .STRIDE(1), .PADDING(1), .SIGNED(1)) u_b (
        .clk(clk), .rst(rst), .data_in_0(din_1), .data_in_0_valid(vin),
        .data_in_0_ready(b_rdy), .data_out_0(b_dout), .data_out_0_valid(b_vout),
        .data_out_0_ready(ordy));

    // c: L=7 K=2 S=2 P=0 (one leftover position per sequence)
    maxpool1d_stream #(.DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(3),
        .DATA_IN_0_TENSOR_SIZE_DIM_0(1), .DATA_IN_0_TENSOR_SIZE_DIM_1(7),
        .KERNEL_SIZE(2), .STRIDE(2), .PADDING(0), .SIGNED(1)) u_c (
        .clk(clk), .rst(rst), .data_in_0(din_1), .data_in_0_valid(vin),
        .data_in_0_ready(c_rdy), .data_out_0(c_dout), .data_out_0_valid(c_vout),
        .data_out_0_ready(ordy));

    // s/u: C=2 L=2 K=2 S=2, signed and unsigned compare
    maxpool1d_stream #(.DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(3),
        .DATA_IN_0_TENSOR_SIZE_DIM_0(2), .DATA_IN_0_TENSOR_SIZE_DIM_1(2),
        .KERNEL_SIZE(2), .STRIDE(2), .PADDING(0), .SIGNED(1)) u_s (
        .clk(clk), .rst(rst), .data_in_0(din_2), .data_in_0_valid(vin),
        .data_in_0_ready(s_rdy), .data_out_0(s_dout), .data_out_0_valid(s_vout),
        .data_out_0_ready(ordy));

    maxpool1d_stream #(.DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(3),
        .DATA_IN_0_TENSOR_SIZE_DIM_0(2), .DATA_IN_0_TENSOR_SIZE_DIM_1(2),
        .KERNEL_SIZE(2), .STRIDE(2), .PADDING(0), .SIGNED(0)) u_u (
        .clk(clk), .rst(rst), .data_in_0(din_2), .data_in_0_valid(vin),
        .data_in_0_ready(u_rdy), .data_out_0(u_dout), .data_out_0_valid(u_vout),
        .data_out_0_ready(ordy));

    // Record every output handshake (ready is changed only just after posedge).
    always @(negedge clk) begin
        if (!rst && ordy) begin
            if (a_vout) qa.push_back(a_dout[0]);
            if (b_vout) qb.push_back(b_dout[0]);
            if (c_vout) qc.push_back(c_dout[0]);
            if (s_vout) qs.push_back(s_dout);
            if (u_vout) qu.push_back(u_dout);
        end
    end

    function automatic bit sel_rdy(input int which);
        case (which)
            0:       return a_rdy;
            1:       return b_rdy;
            2:       return c_rdy;
            default: return s_rdy && u_rdy;
        endcase
    endfunction

    task automatic clear_queues();
        qa.delete(); qb.delete(); qc.delete(); qs.delete(); qu.delete();
    endtask

    task automatic do_reset();
        vin  = 1'b0;
        ordy = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_queues();
    endtask

    // Present beats back to back; returns cycles taken. Entered/left just after a posedge.
    task automatic feed(input int which, input logic [15:0] vals[$], output int cycles);
        int i;
        bit acc;
        i      = 0;
        cycles = 0;
        vin    = 1'b1;
        while (i < vals.size() && cycles < 400) begin
            din_1[0] = vals[i][7:0];
            din_2    = vals[i];
            @(negedge clk);
            acc = sel_rdy(which);
            @(posedge clk); #1;
            if (acc) i++;
            cycles++;
        end
        vin = 1'b0;
        n_checks++;
        if (i != vals.size()) begin
            n_fail++;
            $display("FAIL feed_timeout inst=%0d: accepted %0d beats, required %0d", which, i, vals.size());
        end
    endtask

    task automatic test_reset();
        vin  = 1'b1;
        ordy = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); @(negedge clk);
        n_checks++; if (a_rdy !== 1'b0)  begin n_fail++; $display("FAIL reset_a_ready: got %b, expected 0", a_rdy); end
        n_checks++; if (b_rdy !== 1'b0)  begin n_fail++; $display("FAIL reset_b_ready: got %b, expected 0", b_rdy); end
        n_checks++; if (a_vout !== 1'b0) begin n_fail++; $display("FAIL reset_a_valid: got %b, expected 0", a_vout); end
        n_checks++; if (b_vout !== 1'b0) begin n_fail++; $display("FAIL reset_b_valid: got %b, expected 0", b_vout); end
        n_checks++; if (a_dout !== 8'h00) begin n_fail++; $display("FAIL reset_a_data: got %h, expected 00", a_dout); end
        n_checks++; if (s_dout !== 16'h0000) begin n_fail++; $display("FAIL reset_s_data: got %h, expected 0000", s_dout); end
        n_checks++; if (u_vout !== 1'b0) begin n_fail++; $display("FAIL reset_u_valid: got %b, expected 0", u_vout); end
        @(posedge clk); #1 rst = 1'b0;
        vin = 1'b0;
        @(negedge clk);
        n_checks++; if (a_rdy !== 1'b1) begin n_fail++; $display("FAIL post_reset_a_ready: got %b, expected 1", a_rdy); end
        n_checks++; if (b_rdy !== 1'b0) begin n_fail++; $display("FAIL post_reset_b_lead_ready: got %b, expected 0", b_rdy); end
        @(posedge clk); #1;
    endtask

    task automatic test_stride_pool();
        logic [15:0] v[$];
        logic [7:0]  exp[$];
        logic [7:0]  got;
        int          cyc;
        do_reset();
        v   = '{16'h01, 16'h05, 16'hFD, 16'h02, 16'h07, 16'h07, 16'h00, 16'hFF};
        exp = '{8'h05, 8'h02, 8'h07, 8'h00};
        feed(0, v, cyc);
        repeat (6) @(posedge clk); #1;
        n_checks++;
        if (qa.size() != 4) begin n_fail++; $display("FAIL stride_count: got %0d outputs, expected 4", qa.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < qa.size()) ? qa[i] : 8'hxx;
            n_checks++;
            if (got !== exp[i]) begin n_fail++; $display("FAIL stride_out[%0d]: got %h, expected %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_overlap_pad();
        logic [15:0] v[$];
        logic [7:0]  exp[$];
        logic [7:0]  got;
        logic [7:0]  hist;
        int          cyc;
        do_reset();
        v   = '{16'h03, 16'h01, 16'h04, 16'h01, 16'h05};
        exp = '{8'h03, 8'h04, 8'h04, 8'h05, 8'h05};
        fork
            feed(1, v, cyc);
            begin
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    hist[k] = b_rdy;
                end
            end
        join
        repeat (4) @(posedge clk); #1;
        n_checks++;
        if (hist !== 8'h3E) begin n_fail++; $display("FAIL overlap_ready_pattern: got %b, expected 00111110", hist); end
        n_checks++;
        if (qb.size() != 5) begin n_fail++; $display("FAIL overlap_count: got %0d outputs, expected 5", qb.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (i < qb.size()) ? qb[i] : 8'hxx;
            n_checks++;
            if (got !== exp[i]) begin n_fail++; $display("FAIL overlap_out[%0d]: got %h, expected %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v[$];
        logic [7:0]  exp[$];
        logic [7:0]  got;
        int          cyc;
        do_reset();
        v   = '{16'h01, 16'h05, 16'hFD, 16'h02, 16'h07, 16'h07, 16'h00, 16'hFF,
                16'h04, 16'hFE, 16'hF8, 16'hF7, 16'h7F, 16'h80, 16'h03, 16'h03};
        exp = '{8'h05, 8'h02, 8'h07, 8'h00, 8'h04, 8'hF8, 8'h7F, 8'h03};
        feed(0, v, cyc);
        repeat (6) @(posedge clk); #1;
        n_checks++;
        if (cyc != 16) begin n_fail++; $display("FAIL b2b_cycles: got %0d cycles, expected 16", cyc); end
        n_checks++;
        if (qa.size() != 8) begin n_fail++; $display("FAIL b2b_count: got %0d outputs, expected 8", qa.size()); end
        for (int i = 0; i < 8; i++) begin
            got = (i < qa.size()) ? qa[i] : 8'hxx;
            n_checks++;
            if (got !== exp[i]) begin n_fail++; $display("FAIL b2b_out[%0d]: got %h, expected %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_remainder();
        logic [15:0] v[$];
        logic [7:0]  exp[$];
        logic [7:0]  got;
        int          cyc;
        do_reset();
        v   = '{16'h01, 16'h02, 16'h03, 16'h04, 16'h05, 16'h06, 16'h07,
                16'h09, 16'h08, 16'h03, 16'h04, 16'h06, 16'h05, 16'h02};
        exp = '{8'h02, 8'h04, 8'h06, 8'h09, 8'h04, 8'h06};
        feed(2, v, cyc);
        repeat (6) @(posedge clk); #1;
        n_checks++;
        if (qc.size() != 6) begin n_fail++; $display("FAIL remainder_count: got %0d outputs, expected 6", qc.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < qc.size()) ? qc[i] : 8'hxx;
            n_checks++;
            if (got !== exp[i]) begin n_fail++; $display("FAIL remainder_out[%0d]: got %h, expected %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_signedness();
        logic [15:0] v[$];
        logic [15:0] got;
        int          cyc;
        do_reset();
        v = '{16'h0180, 16'h8001};
        feed(3, v, cyc);
        repeat (4) @(posedge clk); #1;
        n_checks++;
        if (qs.size() != 1 || qu.size() != 1) begin
            n_fail++; $display("FAIL sign_count: got %0d/%0d outputs, expected 1/1", qs.size(), qu.size());
        end
        got = (qs.size() > 0) ? qs[0] : 16'hxxxx;
        n_checks++;
        if (got !== 16'h0101) begin n_fail++; $display("FAIL signed_max: got %h, expected 0101", got); end
        got = (qu.size() > 0) ? qu[0] : 16'hxxxx;
        n_checks++;
        if (got !== 16'h8080) begin n_fail++; $display("FAIL unsigned_max: got %h, expected 8080", got); end
    endtask

    task automatic test_backpressure();
        logic [15:0] v[$];
        logic [7:0]  exp[$];
        logic [7:0]  got;
        int          cyc;
        bit          done;
        do_reset();
        done = 1'b0;
        v   = '{16'h03, 16'h01, 16'h04, 16'h01, 16'h05,
                16'hFF, 16'hFB, 16'hFE, 16'hF9, 16'hFD,
                16'h00, 16'h7F, 16'h80, 16'h00, 16'h0A};
        exp = '{8'h03, 8'h04, 8'h04, 8'h05, 8'h05,
                8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFD,
                8'h7F, 8'h7F, 8'h7F, 8'h0A, 8'h0A};
        fork
            begin
                feed(1, v, cyc);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    ordy = 1'($urandom_range(0, 1));
                end
            end
            begin
                bit         pv;
                bit         pr;
                logic [7:0] pd;
                pv = 1'b0;
                pr = 1'b1;
                pd = 8'h00;
                while (!done) begin
                    @(negedge clk);
                    if (pv && !pr) begin
                        n_checks++;
                        if (b_vout !== 1'b1 || b_dout[0] !== pd) begin
                            n_fail++;
                            $display("FAIL bp_hold: got valid=%b data=%h, expected valid=1 data=%h", b_vout, b_dout[0], pd);
                        end
                    end
                    pv = b_vout;
                    pr = ordy;
                    pd = b_dout[0];
                end
            end
        join
        ordy = 1'b1;
        repeat (10) @(posedge clk); #1;
        n_checks++;
        if (qb.size() != 15) begin n_fail++; $display("FAIL bp_count: got %0d outputs, expected 15", qb.size()); end
        for (int i = 0; i < 15; i++) begin
            got = (i < qb.size()) ? qb[i] : 8'hxx;
            n_checks++;
            if (got !== exp[i]) begin n_fail++; $display("FAIL bp_out[%0d]: got %h, expected %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] v[$];
        logic [7:0]  exp[$];
        logic [7:0]  got;
        int          cyc;
        do_reset();
        v = '{16'h07, 16'h09, 16'h01};
        feed(0, v, cyc);
        ordy = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); @(negedge clk);
        n_checks++; if (a_dout !== 8'h00) begin n_fail++; $display("FAIL midreset_data: got %h, expected 00", a_dout); end
        n_checks++; if (a_vout !== 1'b0)  begin n_fail++; $display("FAIL midreset_valid: got %b, expected 0", a_vout); end
        @(posedge clk); #1 rst = 1'b0;
        ordy = 1'b1;
        clear_queues();
        v   = '{16'h01, 16'h05, 16'hFD, 16'h02, 16'h07, 16'h07, 16'h00, 16'hFF};
        exp = '{8'h05, 8'h02, 8'h07, 8'h00};
        feed(0, v, cyc);
        repeat (6) @(posedge clk); #1;
        n_checks++;
        if (qa.size() != 4) begin n_fail++; $display("FAIL midreset_count: got %0d outputs, expected 4", qa.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < qa.size()) ? qa[i] : 8'hxx;
            n_checks++;
            if (got !== exp[i]) begin n_fail++; $display("FAIL midreset_out[%0d]: got %h, expected %h", i, got, exp[i]); end
        end
    endtask

    initial begin
        rst   = 1'b1;
        vin   = 1'b0;
        ordy  = 1'b1;
        din_1 = '0;
        din_2 = '0;
        test_reset();
        test_stride_pool();
        test_overlap_pad();
        test_back_to_back();
        test_remainder();
        test_signedness();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
